frame_pkt_reader: RTL
=====================

FRAME_PKT_READER -- requirements
Module: frame_pkt_reader

Interface
REQ-001 SHALL have parameter FRAME_BURSTS, default 9600, meaning 64-byte bursts per frame.
REQ-002 SHALL have parameter BURSTS_PER_PKT, default 16, meaning payload words per packet.
REQ-003 SHALL have parameters BASE0 = 32'h2BC0_0000 (buffer 0) and BASE1 = 32'h2BE0_0000 (buffer 1), meaning frame base byte addresses.
REQ-004 SHALL have parameters DST_MAC = 48'hadadadadadad, SRC_MAC = 48'hacacacacacac and ETH_TYPE = 16'h9001, meaning header fields.
REQ-005 SHALL have ports clk input 1, clock; aresetn input 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports frame_start input 1, frame_buf_sel input 1, frame_start_valid input 1, frame_start_ready output 1, meaning start handshake and buffer select.
REQ-007 SHALL have ports frame_done output 1 (1 = no error), frame_done_valid output 1, frame_done_ready input 1.
REQ-008 SHALL have AXI read-address ports M_AXI_ARID out 1, ARADDR out 32, ARLEN out 8, ARSIZE out 3, ARBURST out 2, ARVALID out 1, ARREADY in 1.
REQ-009 SHALL have AXI read-data ports M_AXI_RDATA in 32, RRESP in 2, RLAST in 1, RVALID in 1, RREADY out 1.
REQ-010 SHALL have ports pktout_data output 520 (519:518 flag, 511:0 word), pktout_en output 1, pktout_alf input 1 (downstream almost full).

Function
REQ-011 SHALL drive constants ARID=0, ARLEN=15, ARSIZE=3'b010, ARBURST=2'b01.
REQ-012 SHALL implement states IDLE, HDR, AR, RD, EMIT, DONE.
REQ-013 IDLE: frame_start_ready=1; start accepted when frame_start_valid & frame_start; latch base from frame_buf_sel, clear burst/packet counters and error flag; go to HDR.
REQ-014 frame_start_ready SHALL be 0 in every state except IDLE; starts outside IDLE are ignored.
REQ-015 HDR: when pktout_alf=0, pulse pktout_en one cycle; word = {DST_MAC, SRC_MAC, ETH_TYPE, 16-bit packet seq, 15'b0, buf_sel, zeros}; flag 2'b10; go to AR. If pktout_alf=1, hold.
REQ-016 AR: ARVALID=1 with ARADDR = base + 64*burst_idx; ARADDR SHALL stay stable until ARREADY; on ARVALID & ARREADY deassert and go to RD.
REQ-017 RD: RREADY=1; each RVALID beat k (0..15) written to word[32k +: 32]; after beat 15 go to EMIT.
REQ-018 RRESP!=0 on any beat, or RLAST not coincident with beat 15, SHALL set the sticky error flag; the beat count alone ends the burst.
REQ-019 EMIT: when pktout_alf=0, pulse pktout_en one cycle with the assembled word; flag 2'b01 if last burst of packet or last burst of frame, else 2'b00.
REQ-020 After EMIT: last burst of frame -> DONE; last burst of packet -> HDR with packet seq+1; otherwise -> AR; burst_idx increments by 1 in all cases.
REQ-021 A packet SHALL end early (flag 2'b01) at frame end when FRAME_BURSTS is not a multiple of BURSTS_PER_PKT.
REQ-022 DONE: frame_done_valid=1, frame_done = ~error; hold until frame_done_ready, then return to IDLE next cycle.
REQ-023 Packet seq SHALL be 16 bits, wrap modulo 2^16, and reset to 0 at each accepted start; burst_idx width SHALL cover FRAME_BURSTS.
REQ-024 pktout_en SHALL never be asserted while pktout_alf=1 in the same cycle.
REQ-025 Latency: header pktout_en SHALL be 1 cycle after start acceptance when pktout_alf=0; ARVALID the cycle after header emission.

Reset
REQ-026 On aresetn low, state=IDLE and all outputs 0 except constants of REQ-011; pktout_data 0; counters, error and base cleared.
REQ-027 Reset mid-frame SHALL abandon the frame with no done handshake; the AXI slave is reset by the same aresetn.

Verification
REQ-028 FRAME_BURSTS=4, BURSTS_PER_PKT=2, buf_sel=1, zero-wait slave -> ARADDR 0x2BE00000,+0x40,+0x80,+0xC0; flags 10,00,01,10,00,01; frame_done=1.
REQ-029 Beat k data = k -> emitted word bits[32k+:32] = k for k=0..15.
REQ-030 RRESP=2'b10 on one beat -> all packets still emitted, frame_done=0.
REQ-031 pktout_alf held high 20 cycles during EMIT -> no pktout_en for those cycles; word emitted the cycle after alf falls.
REQ-032 ARREADY delayed 5 cycles -> ARVALID/ARADDR stable throughout; frame_start_valid pulsed mid-frame -> ignored, ready=0.
REQ-033 aresetn asserted in RD -> outputs 0 immediately; next start restarts at base, seq 0.

Source files
------------

// File: rtl/frame_pkt_reader.sv
// Reads a frame from one of two DDR buffers in 64-byte AXI bursts and emits it as
// 512-bit packet words, each packet led by an Ethernet-style header word.
module frame_pkt_reader #(
    parameter int unsigned FRAME_BURSTS   = 9600,
    parameter int unsigned BURSTS_PER_PKT = 16,
    parameter logic [31:0] BASE0          = 32'h2BC0_0000,
    parameter logic [31:0] BASE1          = 32'h2BE0_0000,
    parameter logic [47:0] DST_MAC        = 48'hadadadadadad,
    parameter logic [47:0] SRC_MAC        = 48'hacacacacacac,
    parameter logic [15:0] ETH_TYPE       = 16'h9001
) (
    input  logic         clk,
    input  logic         aresetn,

    input  logic         frame_start,
    input  logic         frame_buf_sel,
    input  logic         frame_start_valid,
    output logic         frame_start_ready,

    output logic         frame_done,
    output logic         frame_done_valid,
    input  logic         frame_done_ready,

    output logic         M_AXI_ARID,
    output logic [31:0]  M_AXI_ARADDR,
    output logic [7:0]   M_AXI_ARLEN,
    output logic [2:0]   M_AXI_ARSIZE,
    output logic [1:0]   M_AXI_ARBURST,
    output logic         M_AXI_ARVALID,
    input  logic         M_AXI_ARREADY,

    input  logic [31:0]  M_AXI_RDATA,
    input  logic [1:0]   M_AXI_RRESP,
    input  logic         M_AXI_RLAST,
    input  logic         M_AXI_RVALID,
    output logic         M_AXI_RREADY,

    output logic [519:0] pktout_data,
    output logic         pktout_en,
    input  logic         pktout_alf
);

    localparam int unsigned BIDX_W = $clog2(FRAME_BURSTS + 1);
    localparam int unsigned PIDX_W = (BURSTS_PER_PKT > 1) ? $clog2(BURSTS_PER_PKT) : 1;

    typedef enum logic [2:0] {StIdle, StHdr, StAr, StRd, StEmit, StDone} state_e;

    state_e              r_state, w_state_d;
    logic [31:0]         r_base;
    logic                r_buf_sel;
    logic [BIDX_W-1:0]   r_burst_idx;
    logic [PIDX_W-1:0]   r_pkt_burst;
    logic [15:0]         r_seq;
    logic                r_err;
    logic [3:0]          r_beat;
    logic [511:0]        r_word;

    logic                w_last_frame;
    logic                w_last_pkt;
    logic                w_beat_bad;
    logic [511:0]        w_hdr_word;

    assign M_AXI_ARID    = 1'b0;
    assign M_AXI_ARLEN   = 8'd15;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;

    assign w_last_frame = (r_burst_idx == BIDX_W'(FRAME_BURSTS - 1));
    assign w_last_pkt   = (r_pkt_burst == PIDX_W'(BURSTS_PER_PKT - 1));
    // The beat counter alone ends the burst; RLAST only feeds the error flag.
    assign w_beat_bad   = (M_AXI_RRESP != 2'b00) || (M_AXI_RLAST != (r_beat == 4'd15));
    assign w_hdr_word   = {DST_MAC, SRC_MAC, ETH_TYPE, r_seq, 15'b0, r_buf_sel, 368'b0};

    always_comb begin
        w_state_d         = r_state;
        frame_start_ready = 1'b0;
        frame_done        = 1'b0;
        frame_done_valid  = 1'b0;
        M_AXI_ARADDR      = 32'h0;
        M_AXI_ARVALID     = 1'b0;
        M_AXI_RREADY      = 1'b0;
        pktout_data       = '0;
        pktout_en         = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Held low while reset is asserted so every handshake output reads 0.
                frame_start_ready = aresetn;
                if (frame_start_valid && frame_start) begin
                    w_state_d = StHdr;
                end
            end
            StHdr: begin
                pktout_data = {2'b10, 6'b0, w_hdr_word};
                if (!pktout_alf) begin
                    pktout_en = 1'b1;
                    w_state_d = StAr;
                end
            end
            StAr: begin
                M_AXI_ARVALID = 1'b1;
                M_AXI_ARADDR  = r_base + (32'(r_burst_idx) << 6);
                if (M_AXI_ARREADY) begin
                    w_state_d = StRd;
                end
            end
            StRd: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID && (r_beat == 4'd15)) begin
                    w_state_d = StEmit;
                end
            end
            StEmit: begin
                pktout_data = {((w_last_pkt || w_last_frame) ? 2'b01 : 2'b00), 6'b0, r_word};
                if (!pktout_alf) begin
                    pktout_en = 1'b1;
                    if (w_last_frame) begin
                        w_state_d = StDone;
                    end else if (w_last_pkt) begin
                        w_state_d = StHdr;
                    end else begin
                        w_state_d = StAr;
                    end
                end
            end
            StDone: begin
                frame_done_valid = 1'b1;
                frame_done       = ~r_err;
                if (frame_done_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= StIdle;
            r_base      <= 32'h0;
            r_buf_sel   <= 1'b0;
            r_burst_idx <= '0;
            r_pkt_burst <= '0;
            r_seq       <= 16'h0;
            r_err       <= 1'b0;
            r_beat      <= 4'h0;
            r_word      <= '0;
        end else begin
            r_state <= w_state_d;
            unique case (r_state)
                StIdle: begin
                    if (frame_start_valid && frame_start) begin
                        r_base      <= frame_buf_sel ? BASE1 : BASE0;
                        r_buf_sel   <= frame_buf_sel;
                        r_burst_idx <= '0;
                        r_pkt_burst <= '0;
                        r_seq       <= 16'h0;
                        r_err       <= 1'b0;
                    end
                end
                StAr: r_beat <= 4'h0;
                StRd: begin
                    if (M_AXI_RVALID) begin
                        r_word[{r_beat, 5'b0} +: 32] <= M_AXI_RDATA;
                        r_beat                      <= r_beat + 4'd1;
                        if (w_beat_bad) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                StEmit: begin
                    if (!pktout_alf) begin
                        r_burst_idx <= r_burst_idx + BIDX_W'(1);
                        if (w_last_pkt || w_last_frame) begin
                            r_pkt_burst <= '0;
                        end else begin
                            r_pkt_burst <= r_pkt_burst + PIDX_W'(1);
                        end
                        if (w_last_pkt && !w_last_frame) begin
                            r_seq <= r_seq + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
